ip_packet_rx_mc: RTL and testbench

IP_PACKET_RX_MC -- requirements
Module: ip_packet_rx_mc

---
 rtl/ip_packet_rx_mc.sv | 229 ++++++++++++++++++++++
 tb/tb_ip_packet_rx_mc.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_packet_rx_mc.sv
// ip_packet_rx_mc: Ethernet/IPv4/UDP receive filter delivering one payload per channel port.
// Define IP_RX_CHECKSUM_EN to also drop frames whose IPv4 header checksum is wrong.
module ip_packet_rx_mc #(
    parameter int USER_DATA_BYTES = 785,
    parameter int NUM_CHANNELS    = 4,
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int DW = USER_DATA_BYTES * 8
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic [47:0]   ACCELERATOR_MAC_ADDRESS,
    input  logic [31:0]   ACCELERATOR_IP_ADDRESS,
    input  logic [15:0]   ACCELERATOR_UDP_PORT,
    input  logic [7:0]    RX_AXIS_TDATA,
    input  logic          RX_AXIS_TVALID,
    input  logic          RX_AXIS_TLAST,
    input  logic          RX_AXIS_TUSER,
    output logic          RX_AXIS_TREADY,
    output logic [DW-1:0] DATA_FRAME,
    output logic [47:0]   SRC_MAC_ADDRESS,
    output logic [31:0]   SRC_IP_ADDRESS,
    output logic [15:0]   SRC_UDP_PORT,
    output logic [CW-1:0] CHANNEL,
    output logic          FRAME_VALID,
    input  logic          FRAME_ACK,
    output logic          PACKET_FOR_ACCELERATOR,
    output logic [15:0]   DROP_COUNT
);

    typedef enum logic [1:0] {HDR, PAYLOAD, DRAIN, HOLD} state_t;

    state_t        state, state_nxt;
    logic          live;
    logic          beat;
    logic [15:0]   idx;
    logic [7:0]    d;
    logic          chk;
    logic [7:0]    exp_byte;
    logic [7:0]    port_hi;
    logic [15:0]   port;
    logic [16:0]   port_lo_lim;
    logic [16:0]   port_hi_lim;
    logic          port_ok;
    logic          csum_fail;
    logic          hdr_fail;
    logic [31:0]   pcnt;
    logic          take;
    logic          drop;
    logic          accept;
    logic          pulse_nxt;
    logic [DW-1:0] pbuf, pbuf_nxt;
    logic [47:0]   src_mac_s;
    logic [31:0]   src_ip_s;
    logic [15:0]   src_port_s;
    logic [CW-1:0] chan_s;

    assign d              = RX_AXIS_TDATA;
    assign RX_AXIS_TREADY = live && (state != HOLD);
    assign beat           = RX_AXIS_TVALID && RX_AXIS_TREADY;
    assign FRAME_VALID    = (state == HOLD);

    // Range check is done one bit wider so base+NUM_CHANNELS-1 cannot wrap.
    assign port        = {port_hi, d};
    assign port_lo_lim = {1'b0, ACCELERATOR_UDP_PORT};
    assign port_hi_lim = port_lo_lim + 17'(NUM_CHANNELS - 1);
    assign port_ok     = ({1'b0, port} >= port_lo_lim) &&
                         ({1'b0, port} <= port_hi_lim);

    always_comb begin
        chk      = 1'b1;
        exp_byte = 8'h00;
        case (idx)
            16'd0:   exp_byte = ACCELERATOR_MAC_ADDRESS[47:40];
            16'd1:   exp_byte = ACCELERATOR_MAC_ADDRESS[39:32];
            16'd2:   exp_byte = ACCELERATOR_MAC_ADDRESS[31:24];
            16'd3:   exp_byte = ACCELERATOR_MAC_ADDRESS[23:16];
            16'd4:   exp_byte = ACCELERATOR_MAC_ADDRESS[15:8];
            16'd5:   exp_byte = ACCELERATOR_MAC_ADDRESS[7:0];
            16'd12:  exp_byte = 8'h08;
            16'd13:  exp_byte = 8'h00;
            16'd14:  exp_byte = 8'h45;
            16'd23:  exp_byte = 8'd17;
            16'd30:  exp_byte = ACCELERATOR_IP_ADDRESS[31:24];
            16'd31:  exp_byte = ACCELERATOR_IP_ADDRESS[23:16];
            16'd32:  exp_byte = ACCELERATOR_IP_ADDRESS[15:8];
            16'd33:  exp_byte = ACCELERATOR_IP_ADDRESS[7:0];
            default: chk = 1'b0;
        endcase
    end

`ifdef IP_RX_CHECKSUM_EN
    logic [15:0] csum;
    logic [7:0]  csum_hi;
    logic [16:0] csum_add;
    logic [15:0] csum_nxt;

    // End-around carry keeps the running value a ones-complement sum.
    always_comb begin
        csum_add  = {1'b0, (idx == 16'd15) ? 16'h0000 : csum} +
                    {1'b0, csum_hi, d};
        csum_nxt  = csum_add[15:0] + {15'd0, csum_add[16]};
        csum_fail = (idx == 16'd33) && (csum_nxt != 16'hFFFF);
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            csum    <= 16'h0000;
            csum_hi <= 8'h00;
        end else if (beat && state == HDR) begin
            if (!idx[0]) csum_hi <= d;
            else         csum    <= csum_nxt;
        end
    end
`else
    assign csum_fail = 1'b0;
`endif

    assign hdr_fail = (chk && d != exp_byte) ||
                      (idx == 16'd37 && !port_ok) ||
                      csum_fail;

    // Payload bytes seen so far including the current beat.
    assign pcnt     = 32'(idx) - 32'd41;
    assign take     = pcnt <= 32'(USER_DATA_BYTES);
    assign pbuf_nxt = take ? ((pbuf << 8) | DW'(d)) : pbuf;

    always_comb begin
        state_nxt = state;
        drop      = 1'b0;
        accept    = 1'b0;
        pulse_nxt = 1'b0;
        unique case (state)
            HDR: begin
                if (beat) begin
                    if (RX_AXIS_TLAST) begin
                        drop = 1'b1;
                    end else if (hdr_fail) begin
                        state_nxt = DRAIN;
                    end else if (idx == 16'd41) begin
                        state_nxt = PAYLOAD;
                        pulse_nxt = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (beat && RX_AXIS_TLAST) begin
                    if (pcnt >= 32'(USER_DATA_BYTES) && !RX_AXIS_TUSER) begin
                        accept    = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        drop      = 1'b1;
                        state_nxt = HDR;
                    end
                end
            end
            DRAIN: begin
                if (beat && RX_AXIS_TLAST) begin
                    drop      = 1'b1;
                    state_nxt = HDR;
                end
            end
            HOLD: begin
                if (FRAME_ACK) state_nxt = HDR;
            end
            default: state_nxt = HDR;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state                  <= HDR;
            live                   <= 1'b0;
            idx                    <= 16'd0;
            PACKET_FOR_ACCELERATOR <= 1'b0;
            DROP_COUNT             <= 16'd0;
        end else begin
            state                  <= state_nxt;
            live                   <= 1'b1;
            PACKET_FOR_ACCELERATOR <= pulse_nxt;
            if (beat) begin
                if (RX_AXIS_TLAST)        idx <= 16'd0;
                else if (idx != 16'hFFFF) idx <= idx + 16'd1;
            end
            if (drop && DROP_COUNT != 16'hFFFF)
                DROP_COUNT <= DROP_COUNT + 16'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            src_mac_s  <= 48'd0;
            src_ip_s   <= 32'd0;
            src_port_s <= 16'd0;
            port_hi    <= 8'd0;
            chan_s     <= '0;
            pbuf       <= '0;
        end else if (beat && state == HDR) begin
            if (idx >= 16'd6 && idx <= 16'd11)
                src_mac_s <= {src_mac_s[39:0], d};
            if (idx >= 16'd26 && idx <= 16'd29)
                src_ip_s <= {src_ip_s[23:0], d};
            if (idx == 16'd34 || idx == 16'd35)
                src_port_s <= {src_port_s[7:0], d};
            if (idx == 16'd36)
                port_hi <= d;
            if (idx == 16'd37)
                chan_s <= CW'(port - ACCELERATOR_UDP_PORT);
        end else if (beat && state == PAYLOAD) begin
            pbuf <= pbuf_nxt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            DATA_FRAME      <= '0;
            SRC_MAC_ADDRESS <= 48'd0;
            SRC_IP_ADDRESS  <= 32'd0;
            SRC_UDP_PORT    <= 16'd0;
            CHANNEL         <= '0;
        end else if (accept) begin
            DATA_FRAME      <= pbuf_nxt;
            SRC_MAC_ADDRESS <= src_mac_s;
            SRC_IP_ADDRESS  <= src_ip_s;
            SRC_UDP_PORT    <= src_port_s;
            CHANNEL         <= chan_s;
        end
    end

endmodule

// File: tb/tb_ip_packet_rx_mc.sv
// tb_ip_packet_rx_mc: random and directed frames against a whole-frame reference model.
// Honours IP_RX_CHECKSUM_EN the same way as the design.
module tb_ip_packet_rx_mc;

    localparam int U  = 785;
    localparam int N  = 4;
    localparam int CW = 2;
    localparam int DW = U * 8;

    logic          aclk = 1'b0;
    logic          areset_n = 1'b0;
    logic [47:0]   mac;
    logic [31:0]   ip;
    logic [15:0]   base_port;
    logic [7:0]    tdata = 8'h00;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic          tuser = 1'b0;
    logic          tready;
    logic [DW-1:0] data_frame;
    logic [47:0]   src_mac;
    logic [31:0]   src_ip;
    logic [15:0]   src_port;
    logic [CW-1:0] channel;
    logic          frame_valid;
    logic          frame_ack = 1'b0;
    logic          pfa;
    logic [15:0]   drop_count;

    ip_packet_rx_mc #(.USER_DATA_BYTES(U), .NUM_CHANNELS(N)) dut (
        .ACLK(aclk),
        .ARESET(areset_n),
        .ACCELERATOR_MAC_ADDRESS(mac),
        .ACCELERATOR_IP_ADDRESS(ip),
        .ACCELERATOR_UDP_PORT(base_port),
        .RX_AXIS_TDATA(tdata),
        .RX_AXIS_TVALID(tvalid),
        .RX_AXIS_TLAST(tlast),
        .RX_AXIS_TUSER(tuser),
        .RX_AXIS_TREADY(tready),
        .DATA_FRAME(data_frame),
        .SRC_MAC_ADDRESS(src_mac),
        .SRC_IP_ADDRESS(src_ip),
        .SRC_UDP_PORT(src_port),
        .CHANNEL(channel),
        .FRAME_VALID(frame_valid),
        .FRAME_ACK(frame_ack),
        .PACKET_FOR_ACCELERATOR(pfa),
        .DROP_COUNT(drop_count)
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc41 = -10;
    int          pulses = 0;
    logic [7:0]  frm[$];
    bit          frm_user;
    logic [15:0] drop_exp = 16'd0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // The pulse must appear the cycle after byte 41 was accepted.
    always @(negedge aclk) begin
        if (areset_n && pfa) begin
            pulses++;
            check("pulse_timing", 64'(cyc), 64'(acc41 + 1));
        end
    end

    // mode: 0 ok, 1 mac, 2 ethertype, 3 version, 4 proto, 5 ip,
    // 9 tuser, 11 checksum, 12 truncated; ports/lengths picked by caller.
    task automatic build(input logic [15:0] dport, input int plen,
                         input bit ramp, input int mode);
        logic [47:0] smac;
        logic [31:0] sip;
        logic [15:0] sport, tl, ul, c;
        int s, keep;
        smac  = {16'($urandom), $urandom};
        sip   = $urandom;
        sport = 16'($urandom);
        tl    = 16'(28 + plen);
        ul    = 16'(8 + plen);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(mac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(smac[47-8*i -: 8]);
        frm.push_back(8'h08); frm.push_back(8'h00);
        frm.push_back(8'h45); frm.push_back(8'h00);
        frm.push_back(tl[15:8]); frm.push_back(tl[7:0]);
        frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
        frm.push_back(8'h40); frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(8'd17);
        frm.push_back(8'h00); frm.push_back(8'h00);
        for (int i = 0; i < 4; i++) frm.push_back(sip[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) frm.push_back(ip[31-8*i -: 8]);
        frm.push_back(sport[15:8]); frm.push_back(sport[7:0]);
        frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
        frm.push_back(ul[15:8]); frm.push_back(ul[7:0]);
        frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
        for (int i = 0; i < plen; i++)
            frm.push_back(ramp ? 8'(i % 17) : 8'($urandom));
        case (mode)
            1: frm[$urandom_range(0, 5)] ^= 8'h01;
            2: frm[13] ^= 8'h01;
            3: frm[14] = 8'h46;
            4: frm[23] = 8'd6;
            5: frm[30 + $urandom_range(0, 3)] ^= 8'h80;
            default: ;
        endcase
        s = 0;
        for (int w = 0; w < 10; w++) s += int'({frm[14+2*w], frm[15+2*w]});
        while (s > 65535) s = (s & 65535) + (s >> 16);
        c = ~16'(s);
        frm[24] = c[15:8];
        frm[25] = c[7:0];
        if (mode == 11) frm[24] ^= 8'h5A;
        if (mode == 12) begin
            keep = $urandom_range(1, 41);
            while (frm.size() > keep) void'(frm.pop_back());
        end
        frm_user = (mode == 9);
    endtask

    function automatic bit hdr_pass();
        int p, s;
        if (frm.size() < 42) return 0;
        for (int i = 0; i < 6; i++)
            if (frm[i] != mac[47-8*i -: 8]) return 0;
        if ({frm[12], frm[13]} != 16'h0800) return 0;
        if (frm[14] != 8'h45 || frm[23] != 8'd17) return 0;
        for (int i = 0; i < 4; i++)
            if (frm[30+i] != ip[31-8*i -: 8]) return 0;
        p = int'({frm[36], frm[37]});
        if (p < int'(base_port) || p > int'(base_port) + N - 1) return 0;
`ifdef IP_RX_CHECKSUM_EN
        s = 0;
        for (int w = 0; w < 10; w++) s += int'({frm[14+2*w], frm[15+2*w]});
        while (s > 65535) s = (s & 65535) + (s >> 16);
        if (s != 65535) return 0;
`else
        s = 0;
`endif
        return 1;
    endfunction

    task automatic send(input int abort_at);
        int n, i, guard;
        n = frm.size();
        i = 0;
        guard = 0;
        acc41 = -10;
        while (i < n && guard < 4 * n + 100) begin
            @(negedge aclk);
            guard++;
            if (i == abort_at) begin
                areset_n = 1'b0;
                tvalid = 1'b0;
                return;
            end
            frame_ack = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                tvalid = 1'b0;
            end else begin
                tvalid = 1'b1;
                tdata  = frm[i];
                tlast  = (i == n - 1);
                tuser  = (i == n - 1) ? frm_user : 1'($urandom);
                if (tready) begin
                    if (i == 41) acc41 = cyc;
                    i++;
                end
            end
        end
        if (i < n) check("send_timeout", 64'(i), 64'(n));
        @(negedge aclk);
        tvalid = 1'b0;
        tlast = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic check_out(input string name);
        logic [DW-1:0] ed;
        logic [15:0] off;
        int k;
        ed = '0;
        for (int j = 0; j < U; j++) ed[DW-1-8*j -: 8] = frm[42+j];
        k = 0;
        for (int j = 0; j < U; j++)
            if (data_frame[DW-1-8*j -: 8] !== ed[DW-1-8*j -: 8]) begin
                k = j;
                break;
            end
        check($sformatf("%s:data[%0d]", name, k),
              64'(data_frame[DW-1-8*k -: 8]), 64'(ed[DW-1-8*k -: 8]));
        check({name, ":src_mac"}, 64'(src_mac),
              64'({frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]}));
        check({name, ":src_ip"}, 64'(src_ip),
              64'({frm[26], frm[27], frm[28], frm[29]}));
        check({name, ":src_port"}, 64'(src_port), 64'({frm[34], frm[35]}));
        off = {frm[36], frm[37]} - base_port;
        check({name, ":channel"}, 64'(channel), 64'(off[CW-1:0]));
    endtask

    task automatic run(input string name);
        bit ok, pl, acc;
        ok  = hdr_pass();
        pl  = ok && frm.size() > 42;
        acc = ok && (frm.size() - 42 >= U) && !frm_user;
        pulses = 0;
        send(-1);
        check({name, ":valid"}, 64'(frame_valid), 64'(acc));
        check({name, ":tready"}, 64'(tready), 64'(!acc));
        check({name, ":pulses"}, 64'(pulses), 64'(pl));
        if (!acc && drop_exp != 16'hFFFF) drop_exp++;
        check({name, ":drops"}, 64'(drop_count), 64'(drop_exp));
        if (acc) begin
            check_out(name);
            repeat ($urandom_range(0, 4)) @(negedge aclk);
            check({name, ":hold_valid"}, 64'(frame_valid), 64'(1));
            check({name, ":hold_tready"}, 64'(tready), 64'(0));
            check_out({name, ":hold"});
            frame_ack = 1'b1;
            @(negedge aclk);
            frame_ack = 1'b0;
            check({name, ":ack_valid"}, 64'(frame_valid), 64'(0));
            check({name, ":ack_tready"}, 64'(tready), 64'(1));
        end
        repeat ($urandom_range(0, 3)) @(negedge aclk);
    endtask

    initial begin
        int mode, plen;
        logic [15:0] dport;
        mac = {16'($urandom), $urandom};
        ip = $urandom;
        base_port = 16'h1000;
        repeat (3) @(negedge aclk);
        check("rst_tready", 64'(tready), 64'(0));
        check("rst_valid", 64'(frame_valid), 64'(0));
        check("rst_pulse", 64'(pfa), 64'(0));
        check("rst_drops", 64'(drop_count), 64'(0));
        check("rst_data", 64'(|data_frame), 64'(0));
        check("rst_src", 64'(|{src_mac, src_ip, src_port}), 64'(0));
        check("rst_channel", 64'(channel), 64'(0));
        areset_n = 1'b1;
        @(negedge aclk);
        check("rel_tready", 64'(tready), 64'(1));

        build(base_port + 16'd2, U, 1, 0);
        run("ramp_ch2");
        build(base_port + 16'(N), U, 0, 0);
        run("port_over");
        build(base_port + 16'd1, U - 1, 0, 0);
        run("short");
        build(base_port + 16'd3, 800, 0, 0);
        run("long");
        build(base_port, U, 0, 0);
        while (frm.size() > 21) void'(frm.pop_back());
        run("tlast20");
        build(base_port, U, 0, 9);
        run("tuser");
        build(base_port + 16'd1, U, 0, 0);
        run("after_tuser");
        build(base_port, U, 0, 11);
        run("bad_csum");
        build(base_port, U, 0, 0);
        run("good_csum");

        base_port = 16'hFFFE;
        build(16'hFFFF, U, 0, 0);
        run("top_port");
        build(16'h0002, U, 0, 0);
        run("wrap_port");
        base_port = 16'h1000;

        for (int r = 0; r < 10; r++) begin
            mode = $urandom_range(0, 12);
            case (mode)
                6:       dport = base_port - 16'd1;
                7:       dport = base_port + 16'(N);
                default: dport = base_port + 16'($urandom_range(0, N - 1));
            endcase
            case (mode)
                8:       plen = U - $urandom_range(1, 40);
                10:      plen = U + $urandom_range(1, 60);
                default: plen = U + $urandom_range(0, 3);
            endcase
            build(dport, plen, 0, mode);
            run($sformatf("rand%0d_m%0d", r, mode));
        end

        build(base_port + 16'd1, U, 0, 0);
        send(42 + 300);
        #1;
        check("midrst_tready", 64'(tready), 64'(0));
        check("midrst_drops", 64'(drop_count), 64'(0));
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        drop_exp = 16'd0;
        @(negedge aclk);
        check("midrst_rel_tready", 64'(tready), 64'(1));
        check("midrst_rel_valid", 64'(frame_valid), 64'(0));
        build(base_port + 16'd3, U, 1, 0);
        run("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
